mrc_ec_sign_resolve: RTL

- Consumes the tail of the 5-skip MRC pipeline: the final reconstructed digit (d5 accumulator after stage 8) and the two redundant sign results (A/B) from the last dual-compare stage.
- Time-aligns the digit with the later-arriving signs and cross-checks the redundant sign channels and the digit range.
- Emits a single resolved sign plus error status.
- Tracks error history through a RUN/DEGRADED/LOCKED state machine, giving the error-correcting TPU datapath a clean accept/reject decision per word.

---
 rtl/mrc_ec_sign_resolve.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mrc_ec_sign_resolve.sv
// MRC tail sign resolver: aligns the final d5 digit with the late redundant sign pair,
// cross-checks both, and tracks error history through a RUN/DEGRADED/LOCKED machine.
module mrc_ec_sign_resolve #(
    parameter int DATA_WIDTH  = 18,
    parameter int MODULUS     = 262049,
    parameter int SGN_SKEW    = 3,
    parameter int CNT_WIDTH   = 16,
    parameter int FAULT_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] d5_in,
    input  logic [1:0]            sgn_in_A,
    input  logic [1:0]            sgn_in_B,
    input  logic                  err_clr,
    output logic                  out_valid,
    output logic [1:0]            out_sign,
    output logic [DATA_WIDTH-1:0] out_digit,
    output logic                  out_err,
    output logic [1:0]            err_status,
    output logic [CNT_WIDTH-1:0]  err_count
);

    // Handshake: valid-only. in_valid qualifies d5_in for one cycle, out_valid is a
    // one-cycle strobe per evaluated word; there is no ready and no backpressure.

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_DEG  = 2'b01;
    localparam logic [1:0] ST_LOCK = 2'b10;

    localparam logic [DATA_WIDTH:0]  LP_MOD     = (DATA_WIDTH+1)'(MODULUS);
    localparam logic [3:0]           LP_LIMIT   = 4'(FAULT_LIMIT);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [SGN_SKEW-1:0]   r_vld_dly;
    logic [DATA_WIDTH-1:0] r_dig_dly [SGN_SKEW];
    logic [1:0]            r_state;
    logic [3:0]            r_consec;
    logic [CNT_WIDTH-1:0]  r_err_count;

    logic                  w_dly_vld;
    logic [DATA_WIDTH-1:0] w_dly_dig;
    logic                  w_word_err;
    logic                  w_emit;
    logic [CNT_WIDTH-1:0]  w_base_cnt;
    logic [3:0]            w_base_consec;
    logic [1:0]            w_base_state;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [3:0]            w_consec_nxt;
    logic [1:0]            w_state_nxt;

    assign w_dly_vld  = r_vld_dly[SGN_SKEW-1];
    assign w_dly_dig  = r_dig_dly[SGN_SKEW-1];
    assign w_word_err = (sgn_in_A != sgn_in_B) || (sgn_in_A == 2'b11) || (sgn_in_B == 2'b11)
                        || ({1'b0, w_dly_dig} >= LP_MOD);
    // Suppression uses the state before any clear, so a word landing on err_clr in LOCKED stays hidden.
    assign w_emit     = w_dly_vld && (r_state != ST_LOCK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_dly <= '0;
            for (int i = 0; i < SGN_SKEW; i++) begin
                r_dig_dly[i] <= '0;
            end
        end else begin
            r_vld_dly[0] <= in_valid;
            r_dig_dly[0] <= d5_in;
            for (int i = 1; i < SGN_SKEW; i++) begin
                r_vld_dly[i] <= r_vld_dly[i-1];
                r_dig_dly[i] <= r_dig_dly[i-1];
            end
        end
    end

    // The clear is applied first, then the word evaluated this cycle is counted on top of it.
    always_comb begin
        w_base_cnt    = err_clr ? '0 : r_err_count;
        w_base_consec = err_clr ? '0 : r_consec;
        w_base_state  = err_clr ? ST_RUN : r_state;
        w_cnt_nxt     = w_base_cnt;
        w_consec_nxt  = w_base_consec;
        w_state_nxt   = w_base_state;
        if (w_dly_vld) begin
            if (w_word_err) begin
                if (w_base_cnt != LP_CNT_MAX) begin
                    w_cnt_nxt = w_base_cnt + CNT_WIDTH'(1);
                end
                if (w_base_consec != 4'hF) begin
                    w_consec_nxt = w_base_consec + 4'd1;
                end
                if (w_consec_nxt >= LP_LIMIT) begin
                    w_state_nxt = ST_LOCK;
                end else if (w_base_state == ST_RUN) begin
                    w_state_nxt = ST_DEG;
                end
            end else begin
                w_consec_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_consec    <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_consec    <= w_consec_nxt;
            r_err_count <= w_cnt_nxt;
        end
    end

    // Result registers hold their last value while LOCKED.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sign  <= 2'b00;
            out_digit <= '0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= w_emit;
            if (w_emit) begin
                out_sign  <= w_word_err ? 2'b11 : sgn_in_A;
                out_digit <= w_dly_dig;
                out_err   <= w_word_err;
            end
        end
    end

    assign err_status = r_state;
    assign err_count  = r_err_count;

endmodule
